// File: rtl/apb_pkg.sv
// Shared definitions for the CPU-to-APB bridge: FSM state encoding,
// default peripheral region constants and peripheral slot indices.
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERROR  = 3'd4
  } apb_state_t;

  localparam logic [31:0] APB_BASE_ADDR = 32'h1000_0000;
  localparam int          APB_WIN_BITS  = 12;

  localparam int GPIO_IDX  = 0;
  localparam int UART_IDX  = 1;
  localparam int TIMER_IDX = 2;
  localparam int FND_IDX   = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational page decoder: maps the upper address bits onto a one-hot
// peripheral select; hit is low when no window matches.
module apb_addr_decoder #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = apb_pkg::APB_BASE_ADDR,
  parameter int          WIN_BITS   = apb_pkg::APB_WIN_BITS
) (
  input  logic [31-WIN_BITS:0]  page,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  localparam int PAGE_W = 32 - WIN_BITS;
  localparam logic [PAGE_W-1:0] BASE_PAGE = BASE_ADDR[31:WIN_BITS];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (page == BASE_PAGE + PAGE_W'(i));
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/apb_master.sv
// CPU data-bus to APB bridge with SETUP/ACCESS sequencing and one-cycle ready.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = APB_BASE_ADDR,
  parameter int          WIN_BITS   = APB_WIN_BITS
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  apb_state_t state_q, state_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  hit_q;
  logic                  pready_sel;
  logic [31:0]           prdata_sel;
  logic                  timeout;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .WIN_BITS   (WIN_BITS)
  ) u_decoder (
    .page (addr[31:WIN_BITS]),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Only the latched slave's handshake and data are observed.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        pready_sel = pready_sel | PREADY[i];
        prdata_sel = prdata_sel | PRDATA[32*i +: 32];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_q != ACCESS) begin
      wait_cnt <= '0;
    end else if (!pready_sel) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout = (state_q == ACCESS) && !pready_sel &&
                   (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      hit_q   <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && transfer) begin
        PADDR  <= addr;
        PWDATA <= wdata;
        PWRITE <= write;
        sel_q  <= dec_sel;
        hit_q  <= dec_hit;
      end
      if (state_q == ACCESS && pready_sel && !PWRITE) begin
        rdata <= prdata_sel;
      end
      if (state_d == ERROR) begin
        rdata <= '0;
      end
    end
  end

  // An unmapped request still spends its first cycle in SETUP with no select
  // raised, so the error response lands one cycle after the strobe is taken.
  always_comb begin
    state_d = state_q;
    PSEL    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (transfer) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = sel_q;
        state_d = hit_q ? ACCESS : ERROR;
      end
      ACCESS: begin
        PSEL    = sel_q;
        PENABLE = 1'b1;
        if (pready_sel)   state_d = RESP;
        else if (timeout) state_d = ERROR;
      end
      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: handshake timing, decode windows, held strobe,
// reset abort and the ACCESS watchdog (or its absence).
module tb_apb_master;

  logic         clk = 1'b0;
  logic         reset;
  logic         transfer;
  logic         write;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic         PWRITE;
  logic         PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;

  int n_checks = 0;
  int n_errs   = 0;

  apb_master #(.NUM_SLAVES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One request with the strobe dropped after it is taken; ready is awaited
  // with a cycle budget and the latency counted from the accepting edge.
  task automatic run_xfer(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] exp_sel,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_lat);
    int lat;
    addr = a; write = w; wdata = d; transfer = 1'b1;
    tick();
    lat = 1;
    transfer = 1'b0;
    check({tag, " psel"}, 32'(PSEL), 32'(exp_sel));
    while (!ready && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " rdata"}, rdata, exp_rdata);
    tick();
    check({tag, " ready drop"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int n_ready;
    reset = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = 4'b1111;
    PRDATA = {32'h7777_3333, 32'h0000_00A5, 32'h1111_2222, 32'hCAFE_F00D};
    #1;
    check("reset outputs", {rdata[31:2], ready, err}, 32'd0);
    check("reset paddr", PADDR, 32'd0);
    check("reset pwdata", PWDATA, 32'd0);
    check("reset ctrl", {25'd0, PWRITE, PENABLE, PSEL, rdata[1:0]}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // zero-wait write to slave 0
    addr = 32'h1000_0004; wdata = 32'hDEAD_BEEF; write = 1'b1; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    check("zw c1 psel", 32'(PSEL), 32'h1);
    check("zw c1 penable", 32'(PENABLE), 32'd0);
    tick();
    check("zw c2 penable", 32'(PENABLE), 32'd1);
    check("zw c2 psel", 32'(PSEL), 32'h1);
    check("zw c2 paddr", PADDR, 32'h1000_0004);
    check("zw c2 pwdata", PWDATA, 32'hDEAD_BEEF);
    check("zw c2 pwrite", 32'(PWRITE), 32'd1);
    check("zw c2 ready", 32'(ready), 32'd0);
    tick();
    check("zw c3 ready", 32'(ready), 32'd1);
    check("zw c3 err", 32'(err), 32'd0);
    check("zw c3 psel", 32'(PSEL), 32'd0);
    check("zw c3 rdata", rdata, 32'd0);
    tick();
    check("zw c4 ready", 32'(ready), 32'd0);

    // wait-state read of slave 2 with the strobe held high throughout
    PREADY = 4'b1011;
    addr = 32'h1000_2010; write = 1'b0; wdata = 32'h0; transfer = 1'b1;
    n_ready = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (cyc == 5) PREADY = 4'b1111;
      if (ready) n_ready++;
      if (cyc <= 5) begin
        check($sformatf("ws c%0d psel", cyc), 32'(PSEL), 32'h4);
        check($sformatf("ws c%0d paddr", cyc), PADDR, 32'h1000_2010);
        check($sformatf("ws c%0d penable", cyc), 32'(PENABLE), (cyc == 1) ? 32'd0 : 32'd1);
      end
    end
    check("ws c6 ready", 32'(ready), 32'd1);
    check("ws c6 err", 32'(err), 32'd0);
    check("ws c6 rdata", rdata, 32'h0000_00A5);
    check("ws c6 psel", 32'(PSEL), 32'd0);
    check("ws single ready", n_ready, 32'd1);
    PRDATA[95:64] = 32'h0000_005A;
    tick();
    check("ws c7 idle psel", 32'(PSEL), 32'd0);
    check("ws c7 ready", 32'(ready), 32'd0);
    check("ws c7 rdata hold", rdata, 32'h0000_00A5);
    tick();
    transfer = 1'b0;
    check("ws c8 resetup psel", 32'(PSEL), 32'h4);
    check("ws c8 penable", 32'(PENABLE), 32'd0);
    tick();
    check("ws c9 penable", 32'(PENABLE), 32'd1);
    tick();
    check("ws c10 ready", 32'(ready), 32'd1);
    check("ws c10 rdata", rdata, 32'h0000_005A);
    tick();

    // decode windows, write leaving rdata alone, unmapped boundaries
    run_xfer("wr s3 top", 32'h1000_3FFC, 1'b1, 32'h1234_5678, 4'b1000, 1'b0, 32'h0000_005A, 3);
    run_xfer("rd s1", 32'h1000_1000, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h1111_2222, 3);
    run_xfer("unmapped hi", 32'h2000_0000, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 2);
    run_xfer("rd s3", 32'h1000_3000, 1'b0, 32'h0, 4'b1000, 1'b0, 32'h7777_3333, 3);
    run_xfer("unmapped s4", 32'h1000_4000, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 2);
    run_xfer("unmapped below", 32'h0FFF_FFFC, 1'b1, 32'h5555_AAAA, 4'b0000, 1'b1, 32'h0, 2);
    run_xfer("rd s0", 32'h1000_0000, 1'b0, 32'h0, 4'b0001, 1'b0, 32'hCAFE_F00D, 3);

    // reset during ACCESS aborts without a ready pulse
    PREADY = 4'b1101;
    addr = 32'h1000_1008; write = 1'b0; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    tick();
    check("rst pre penable", 32'(PENABLE), 32'd1);
    check("rst pre psel", 32'(PSEL), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("rst async psel", 32'(PSEL), 32'd0);
    check("rst async penable", 32'(PENABLE), 32'd0);
    check("rst async paddr", PADDR, 32'd0);
    check("rst async ready", 32'(ready), 32'd0);
    check("rst async rdata", rdata, 32'd0);
    tick(); tick();
    reset = 1'b0;
    PREADY = 4'b1111;
    n_ready = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (ready || PENABLE) n_ready++;
    end
    check("rst no activity", n_ready, 32'd0);
    run_xfer("post rst rd s1", 32'h1000_1004, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h1111_2222, 3);

`ifdef APB_MASTER_TIMEOUT_EN
    // 16 wait cycles in ACCESS (cycles 2..17) then ERROR in cycle 18
    PREADY = 4'b1110;
    run_xfer("timeout", 32'h1000_0010, 1'b0, 32'h0, 4'b0001, 1'b1, 32'h0, 18);
    PREADY = 4'b1111;
    run_xfer("after timeout", 32'h1000_0000, 1'b0, 32'h0, 4'b0001, 1'b0, 32'hCAFE_F00D, 3);
`else
    // without the watchdog a stalled slave holds the access indefinitely
    PREADY = 4'b1110;
    addr = 32'h1000_0010; write = 1'b0; transfer = 1'b1;
    tick();
    transfer = 1'b0;
    tick();
    n_ready = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (!PENABLE || ready || err) n_ready++;
      tick();
    end
    check("no timeout stall", n_ready, 32'd0);
    check("no timeout psel", 32'(PSEL), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    PREADY = 4'b1111;
    run_xfer("after stall", 32'h1000_0000, 1'b0, 32'h0, 4'b0001, 1'b0, 32'hCAFE_F00D, 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
